// File: rtl/ristretto_if_stage_pkg.sv
// Shared IF-stage types: the fetch-unit FSM encoding and the PC increment.
package ristretto_if_stage_pkg;

  typedef enum logic [1:0] {
    FU_IDLE,
    FU_REQ,
    FU_WAIT,
    FU_DISCARD
  } fu_state_e;

  localparam int unsigned FU_PC_STEP = 4;

endpackage

// File: rtl/ristretto_fetch_unit.sv
// Instruction fetch unit: one outstanding req/gnt/rvalid transaction per fetch request,
// PC tracking, redirect handling and discard of stale in-flight responses.
module ristretto_fetch_unit
  import ristretto_if_stage_pkg::*;
#(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          AddrWidth = 32,
  parameter logic [AddrWidth-1:0] ResetPc   = '0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 fu_fetch_i,
  output logic                 fu_busy_o,
  output logic                 fu_new_instr_o,
  output logic [DataWidth-1:0] fu_instr_o,
  output logic [AddrWidth-1:0] fu_current_pc_o,
  input  logic                 fu_redirect_i,
  input  logic [AddrWidth-1:0] fu_redirect_pc_i,
  output logic                 instr_req_o,
  output logic [AddrWidth-1:0] instr_addr_o,
  input  logic                 instr_gnt_i,
  input  logic                 instr_rvalid_i,
  input  logic [DataWidth-1:0] instr_rdata_i
);

  fu_state_e            state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [AddrWidth-1:0] redir_pc_q, redir_pc_d;
  logic                 flush_q, flush_d;
  logic [DataWidth-1:0] instr_q, instr_d;
  logic                 new_instr_q, new_instr_d;

  logic [AddrWidth-1:0] redir_target;
  logic [AddrWidth-1:0] pc_inc;

  assign redir_target = fu_redirect_pc_i & ~AddrWidth'(3);
  assign pc_inc       = pc_q + AddrWidth'(FU_PC_STEP);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_pc_d  = redir_pc_q;
    flush_d     = flush_q;
    instr_d     = instr_q;
    new_instr_d = 1'b0;

    unique case (state_q)
      FU_IDLE: begin
        if (fu_redirect_i) begin
          pc_d = redir_target;
        end else if (fu_fetch_i) begin
          if (instr_gnt_i) begin
            state_d = FU_WAIT;
            pc_d    = pc_inc;
          end else begin
            state_d = FU_REQ;
          end
        end
      end

      FU_REQ: begin
        // The request cannot be withdrawn, so a redirect here is remembered and
        // the response of the already-issued request is discarded later.
        if (instr_gnt_i) begin
          if (flush_q || fu_redirect_i) begin
            state_d = FU_DISCARD;
            flush_d = 1'b1;
            pc_d    = fu_redirect_i ? redir_target : redir_pc_q;
          end else begin
            state_d = FU_WAIT;
            pc_d    = pc_inc;
          end
        end else if (fu_redirect_i) begin
          flush_d    = 1'b1;
          redir_pc_d = redir_target;
        end
      end

      FU_WAIT: begin
        if (instr_rvalid_i) begin
          state_d = FU_IDLE;
          if (fu_redirect_i) begin
            pc_d = redir_target;
          end else begin
            instr_d     = instr_rdata_i;
            new_instr_d = 1'b1;
          end
        end else if (fu_redirect_i) begin
          state_d = FU_DISCARD;
          pc_d    = redir_target;
        end
      end

      FU_DISCARD: begin
        if (fu_redirect_i) begin
          pc_d = redir_target;
        end
        if (instr_rvalid_i) begin
          state_d = FU_IDLE;
          flush_d = 1'b0;
        end
      end

      default: state_d = FU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= FU_IDLE;
      pc_q        <= ResetPc;
      redir_pc_q  <= ResetPc;
      flush_q     <= 1'b0;
      instr_q     <= '0;
      new_instr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_pc_q  <= redir_pc_d;
      flush_q     <= flush_d;
      instr_q     <= instr_d;
      new_instr_q <= new_instr_d;
    end
  end

  assign fu_busy_o       = (state_q != FU_IDLE);
  assign instr_req_o     = ((state_q == FU_IDLE) && fu_fetch_i && !fu_redirect_i) ||
                           (state_q == FU_REQ);
  assign instr_addr_o    = pc_q;
  assign fu_current_pc_o = pc_q;
  assign fu_new_instr_o  = new_instr_q;
  assign fu_instr_o      = instr_q;

endmodule

// File: tb/tb_ristretto_fetch_unit.sv
// Directed cycle-by-cycle vectors for the fetch unit plus an async-reset sequence.
module tb_ristretto_fetch_unit;

  logic        clk;
  logic        rstn;
  logic        fetch;
  logic        busy;
  logic        new_instr;
  logic [31:0] instr;
  logic [31:0] cur_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  int tests_run = 0;
  int tests_failed = 0;

  ristretto_fetch_unit dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .fu_fetch_i      (fetch),
    .fu_busy_o       (busy),
    .fu_new_instr_o  (new_instr),
    .fu_instr_o      (instr),
    .fu_current_pc_o (cur_pc),
    .fu_redirect_i   (redirect),
    .fu_redirect_pc_i(redirect_pc),
    .instr_req_o     (req),
    .instr_addr_o    (addr),
    .instr_gnt_i     (gnt),
    .instr_rvalid_i  (rvalid),
    .instr_rdata_i   (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fetch;
    logic        redirect;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic        e_new;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic f, logic r, logic [31:0] rp, logic g, logic v,
                              logic [31:0] d, logic er, logic [31:0] ea, logic eb,
                              logic en, logic [31:0] ei, logic [31:0] ep);
    vec_t t;
    t.fetch = f; t.redirect = r; t.rpc = rp; t.gnt = g; t.rvalid = v; t.rdata = d;
    t.e_req = er; t.e_addr = ea; t.e_busy = eb; t.e_new = en; t.e_instr = ei; t.e_pc = ep;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic er, input logic [31:0] ea,
                           input logic eb, input logic en, input logic [31:0] ei,
                           input logic [31:0] ep);
    check({tag, " req"}, 32'(req), 32'(er));
    check({tag, " addr"}, addr, ea);
    check({tag, " busy"}, 32'(busy), 32'(eb));
    check({tag, " new_instr"}, 32'(new_instr), 32'(en));
    check({tag, " instr"}, instr, ei);
    check({tag, " pc"}, cur_pc, ep);
  endtask

  initial begin
    // Each row is one cycle: inputs driven, outputs expected before the next posedge.
    //                 fetch red rpc            gnt rv rdata          req addr           busy new instr          pc
    // 1: zero-wait fetch; stray rvalid while idle is ignored
    vq.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, 0, 32'h0,        32'h0));
    vq.push_back(mk(0, 0, 32'h0,          0, 1, 32'h0050_0093,  0, 32'h4,          1, 0, 32'h0,        32'h4));
    vq.push_back(mk(0, 0, 32'h0,          0, 1, 32'h0000_0BAD,  0, 32'h4,          0, 1, 32'h0050_0093, 32'h4));
    // 2: grant delayed 3 cycles
    vq.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h4,          0, 0, 32'h0050_0093, 32'h4));
    vq.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h4,          1, 0, 32'h0050_0093, 32'h4));
    vq.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h4,          1, 0, 32'h0050_0093, 32'h4));
    vq.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h4,          1, 0, 32'h0050_0093, 32'h4));
    vq.push_back(mk(0, 0, 32'h0,          0, 1, 32'h1111_1111,  0, 32'h8,          1, 0, 32'h0050_0093, 32'h8));
    vq.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h8,          0, 1, 32'h1111_1111, 32'h8));
    // 3: redirect in WAIT before rvalid
    vq.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h8,          0, 0, 32'h1111_1111, 32'h8));
    vq.push_back(mk(0, 1, 32'h100,        0, 0, 32'h0,          0, 32'hC,          1, 0, 32'h1111_1111, 32'hC));
    vq.push_back(mk(0, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,  0, 32'h100,        1, 0, 32'h1111_1111, 32'h100));
    vq.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h100,        0, 0, 32'h1111_1111, 32'h100));
    vq.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h100,        1, 0, 32'h1111_1111, 32'h100));
    vq.push_back(mk(0, 0, 32'h0,          0, 1, 32'h2222_2222,  0, 32'h104,        1, 0, 32'h1111_1111, 32'h104));
    vq.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h104,        0, 1, 32'h2222_2222, 32'h104));
    // 4: redirect in REQ; request held, response dropped
    vq.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h104,        0, 0, 32'h2222_2222, 32'h104));
    vq.push_back(mk(1, 1, 32'h200,        0, 0, 32'h0,          1, 32'h104,        1, 0, 32'h2222_2222, 32'h104));
    vq.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h104,        1, 0, 32'h2222_2222, 32'h104));
    vq.push_back(mk(0, 0, 32'h0,          0, 1, 32'h3333_3333,  0, 32'h200,        1, 0, 32'h2222_2222, 32'h200));
    vq.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h200,        0, 0, 32'h2222_2222, 32'h200));
    vq.push_back(mk(0, 0, 32'h0,          0, 1, 32'h4444_4444,  0, 32'h204,        1, 0, 32'h2222_2222, 32'h204));
    vq.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h204,        0, 1, 32'h4444_4444, 32'h204));
    // 5: redirect coinciding with rvalid
    vq.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h204,        0, 0, 32'h4444_4444, 32'h204));
    vq.push_back(mk(0, 1, 32'h300,        0, 1, 32'h5555_5555,  0, 32'h208,        1, 0, 32'h4444_4444, 32'h208));
    vq.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h300,        0, 0, 32'h4444_4444, 32'h300));
    vq.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h300,        1, 0, 32'h4444_4444, 32'h300));
    vq.push_back(mk(0, 0, 32'h0,          0, 1, 32'h6666_6666,  0, 32'h304,        1, 0, 32'h4444_4444, 32'h304));
    vq.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h304,        0, 1, 32'h6666_6666, 32'h304));
    // 6: redirect in IDLE suppresses req; misaligned target masked; PC wraps to 0
    vq.push_back(mk(1, 1, 32'hFFFF_FFFE,  0, 0, 32'h0,          0, 32'h304,        0, 0, 32'h6666_6666, 32'h304));
    vq.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 0, 32'h6666_6666, 32'hFFFF_FFFC));
    vq.push_back(mk(0, 0, 32'h0,          0, 1, 32'h7777_7777,  0, 32'h0,          1, 0, 32'h6666_6666, 32'h0));
    vq.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 1, 32'h7777_7777, 32'h0));

    rstn = 1'b0; fetch = 1'b0; redirect = 1'b0; redirect_pc = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    @(negedge clk);
    #1;
    check_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rstn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      fetch = vq[i].fetch; redirect = vq[i].redirect; redirect_pc = vq[i].rpc;
      gnt = vq[i].gnt; rvalid = vq[i].rvalid; rdata = vq[i].rdata;
      #1;
      check_all($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_busy,
                vq[i].e_new, vq[i].e_instr, vq[i].e_pc);
    end

    // Async reset while in WAIT, then a late rvalid that must be ignored.
    @(negedge clk);
    fetch = 1'b1; redirect = 1'b0; gnt = 1'b1; rvalid = 1'b0;
    #1;
    check("rst_seq req", 32'(req), 32'h1);
    @(negedge clk);
    fetch = 1'b0; gnt = 1'b0;
    #1;
    check("rst_seq busy_in_wait", 32'(busy), 32'h1);
    check("rst_seq pc_in_wait", cur_pc, 32'h4);
    rstn = 1'b0;
    #1;
    check_all("rst_async", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b1; rvalid = 1'b1; rdata = 32'h8888_8888;
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    check_all("late_rvalid", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
